// File: rtl/carfield_pkg.sv
// Shared constants and register map for the Carfield inter-domain mailbox window.
package carfield_pkg;

    localparam int unsigned MailboxStride = 'h40;
    localparam int unsigned MailboxNumMax = 64;

    typedef enum logic [3:0] {
        SndStat = 4'd0,
        SndSet  = 4'd1,
        SndClr  = 4'd2,
        SndEn   = 4'd3,
        RcvStat = 4'd4,
        RcvSet  = 4'd5,
        RcvClr  = 4'd6,
        RcvEn   = 4'd7,
        Letter0 = 4'd8,
        Letter1 = 4'd9
    } mbox_reg_e;

endpackage

// File: rtl/carfield_mailbox_unit.sv
// One mailbox: sender/receiver doorbell status and enables, two letters, and its IRQs.
module carfield_mailbox_unit
    import carfield_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  mbox_reg_e   i_reg,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic [31:0] o_rdata,
    output logic        o_sndIrq,
    output logic        o_rcvIrq
);

    logic        r_sndStat;
    logic        r_sndEn;
    logic        r_rcvStat;
    logic        r_rcvEn;
    logic [31:0] r_letter0;
    logic [31:0] r_letter1;
    logic [31:0] w_rdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sndStat <= 1'b0;
            r_sndEn   <= 1'b0;
            r_rcvStat <= 1'b0;
            r_rcvEn   <= 1'b0;
            r_letter0 <= '0;
            r_letter1 <= '0;
        end else if (i_we) begin
            case (i_reg)
                SndSet:  if (i_wstrb[0] && i_wdata[0]) r_sndStat <= 1'b1;
                SndClr:  if (i_wstrb[0] && i_wdata[0]) r_sndStat <= 1'b0;
                SndEn:   if (i_wstrb[0]) r_sndEn <= i_wdata[0];
                RcvSet:  if (i_wstrb[0] && i_wdata[0]) r_rcvStat <= 1'b1;
                RcvClr:  if (i_wstrb[0] && i_wdata[0]) r_rcvStat <= 1'b0;
                RcvEn:   if (i_wstrb[0]) r_rcvEn <= i_wdata[0];
                Letter0: begin
                    for (int b = 0; b < 4; b++) begin
                        if (i_wstrb[b]) r_letter0[8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
                Letter1: begin
                    for (int b = 0; b < 4; b++) begin
                        if (i_wstrb[b]) r_letter1[8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

    // SET/CLR are write-only strobes and read back as zero.
    always_comb begin
        w_rdata = '0;
        case (i_reg)
            SndStat: w_rdata[0] = r_sndStat;
            SndEn:   w_rdata[0] = r_sndEn;
            RcvStat: w_rdata[0] = r_rcvStat;
            RcvEn:   w_rdata[0] = r_rcvEn;
            Letter0: w_rdata    = r_letter0;
            Letter1: w_rdata    = r_letter1;
            default: w_rdata    = '0;
        endcase
    end

    assign o_rdata  = w_rdata;
    assign o_sndIrq = r_sndStat & r_sndEn;
    assign o_rcvIrq = r_rcvStat & r_rcvEn;

endmodule

// File: rtl/carfield_mailbox_resp.sv
// Register-bus responder for the mailbox window: address decode, error checks,
// one-deep response register, and the array of mailbox units.
module carfield_mailbox_resp
    import carfield_pkg::*;
#(
    parameter int unsigned          NumMailboxes = 25,
    parameter int unsigned          AddrWidth    = 32,
    parameter logic [AddrWidth-1:0] BaseAddr     = 'h4000_0000,
    parameter int unsigned          DataWidth    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AddrWidth-1:0]    req_addr_i,
    input  logic                    req_write_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [3:0]              req_wstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DataWidth-1:0]    rsp_rdata_o,
    output logic                    rsp_error_o,
    output logic [NumMailboxes-1:0] snd_irq_o,
    output logic [NumMailboxes-1:0] rcv_irq_o
);

    localparam int unsigned        IdxWidth   = $clog2(MailboxNumMax);
    localparam int unsigned        StrideBits = $clog2(MailboxStride);
    localparam logic [IdxWidth:0]  MboxCount  = (IdxWidth+1)'(NumMailboxes);

    logic [11:2]          w_offWord;
    logic [IdxWidth-1:0]  w_idx;
    mbox_reg_e            w_reg;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_wrEn;
    logic [31:0]          w_unitRdata [NumMailboxes];
    logic [31:0]          w_selRdata;

    logic                 r_rspValid;
    logic [DataWidth-1:0] r_rspRdata;
    logic                 r_rspError;

    assign w_offWord = 10'((req_addr_i - BaseAddr) >> 2);
    assign w_idx     = w_offWord[11:StrideBits];
    assign w_reg     = mbox_reg_e'(w_offWord[StrideBits-1:2]);

    always_comb begin
        w_err = 1'b0;
        if (req_addr_i < BaseAddr)                          w_err = 1'b1;
        if ({1'b0, w_idx} >= MboxCount)                     w_err = 1'b1;
        if (req_addr_i[1:0] != 2'b00)                       w_err = 1'b1;
        if (w_reg > Letter1)                                w_err = 1'b1;
        if (req_write_i && (w_reg == SndStat || w_reg == RcvStat)) w_err = 1'b1;
    end

    // A new request may enter whenever the response slot is empty or being drained.
    assign req_ready_o = !r_rspValid || rsp_ready_i;
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_wrEn      = w_accept && req_write_i && !w_err;

    always_comb begin
        w_selRdata = '0;
        for (int i = 0; i < int'(NumMailboxes); i++) begin
            if (w_idx == IdxWidth'(i)) w_selRdata = w_unitRdata[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspError <= 1'b0;
        end else if (w_accept) begin
            r_rspValid <= 1'b1;
            r_rspRdata <= (req_write_i || w_err) ? '0 : w_selRdata;
            r_rspError <= w_err;
        end else if (rsp_ready_i) begin
            r_rspValid <= 1'b0;
        end
    end

    assign rsp_valid_o = r_rspValid;
    assign rsp_rdata_o = r_rspRdata;
    assign rsp_error_o = r_rspError;

    for (genvar g = 0; g < int'(NumMailboxes); g++) begin : g_mbox
        carfield_mailbox_unit u_unit (
            .i_clk    (clk_i),
            .i_rst    (rst_i),
            .i_we     (w_wrEn && (w_idx == IdxWidth'(g))),
            .i_reg    (w_reg),
            .i_wdata  (req_wdata_i),
            .i_wstrb  (req_wstrb_i),
            .o_rdata  (w_unitRdata[g]),
            .o_sndIrq (snd_irq_o[g]),
            .o_rcvIrq (rcv_irq_o[g])
        );
    end

endmodule

// File: tb/tb_carfield_mailbox_resp.sv
// Scoreboard bench for carfield_mailbox_resp: directed scenarios then random traffic,
// all responses and IRQs compared against a behavioural model of the mailbox window.
module tb_carfield_mailbox_resp;

    localparam int          NumMbox = 25;
    localparam logic [31:0] Base    = 32'h4000_0000;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               req_valid_i = 1'b0;
    logic               req_ready_o;
    logic [31:0]        req_addr_i = '0;
    logic               req_write_i = 1'b0;
    logic [31:0]        req_wdata_i = '0;
    logic [3:0]         req_wstrb_i = '0;
    logic               rsp_valid_o;
    logic               rsp_ready_i = 1'b1;
    logic [31:0]        rsp_rdata_o;
    logic               rsp_error_o;
    logic [NumMbox-1:0] snd_irq_o;
    logic [NumMbox-1:0] rcv_irq_o;

    int nVectors     = 0;
    int nMiscompares = 0;
    bit randReady    = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sbQ[$];

    bit          sndStat [64];
    bit          sndEn   [64];
    bit          rcvStat [64];
    bit          rcvEn   [64];
    logic [31:0] letter0 [64];
    logic [31:0] letter1 [64];

    bit          prevValid    = 1'b0;
    bit          prevConsumed = 1'b0;
    logic [31:0] prevRdata    = '0;
    logic        prevErr      = 1'b0;

    carfield_mailbox_resp #(
        .NumMailboxes (NumMbox),
        .AddrWidth    (32),
        .BaseAddr     (Base),
        .DataWidth    (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_write_i (req_write_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .snd_irq_o   (snd_irq_o),
        .rcv_irq_o   (rcv_irq_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 64; i++) begin
            sndStat[i] = 1'b0;
            sndEn[i]   = 1'b0;
            rcvStat[i] = 1'b0;
            rcvEn[i]   = 1'b0;
            letter0[i] = '0;
            letter1[i] = '0;
        end
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] res = old;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [63:0] modelIrq(input bit snd);
        logic [63:0] v = '0;
        for (int i = 0; i < NumMbox; i++) begin
            v[i] = snd ? (sndStat[i] & sndEn[i]) : (rcvStat[i] & rcvEn[i]);
        end
        return v;
    endfunction

    // Window semantics expressed as byte offsets within a 64-byte mailbox slot.
    task automatic modelAccess(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                               input logic [3:0] wstrb, output logic [31:0] rdata, output logic err);
        int unsigned off;
        int unsigned idx;
        int unsigned r;
        rdata = '0;
        err   = 1'b0;
        idx   = 0;
        r     = 0;
        if (addr < Base) begin
            err = 1'b1;
        end else begin
            off = addr - Base;
            idx = off / 64;
            r   = off % 64;
            if (idx >= NumMbox || (addr % 4) != 0 || r >= 40 || (write && (r == 0 || r == 16)))
                err = 1'b1;
        end
        if (!err) begin
            if (write) begin
                case (r)
                    4:  if (wstrb[0] && wdata[0]) sndStat[idx] = 1'b1;
                    8:  if (wstrb[0] && wdata[0]) sndStat[idx] = 1'b0;
                    12: if (wstrb[0]) sndEn[idx] = wdata[0];
                    20: if (wstrb[0] && wdata[0]) rcvStat[idx] = 1'b1;
                    24: if (wstrb[0] && wdata[0]) rcvStat[idx] = 1'b0;
                    28: if (wstrb[0]) rcvEn[idx] = wdata[0];
                    32: letter0[idx] = mergeBytes(letter0[idx], wdata, wstrb);
                    36: letter1[idx] = mergeBytes(letter1[idx], wdata, wstrb);
                    default: ;
                endcase
            end else begin
                case (r)
                    0:  rdata = {31'd0, sndStat[idx]};
                    12: rdata = {31'd0, sndEn[idx]};
                    16: rdata = {31'd0, rcvStat[idx]};
                    28: rdata = {31'd0, rcvEn[idx]};
                    32: rdata = letter0[idx];
                    36: rdata = letter1[idx];
                    default: rdata = '0;
                endcase
            end
        end
    endtask

    // Monitor: IRQs reflect everything accepted before the last edge; responses pop the scoreboard.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] rd;
        logic        er;
        if (rst_i) begin
            modelReset();
            sbQ.delete();
            prevValid    = 1'b0;
            prevConsumed = 1'b0;
        end else begin
            checkOutput("snd_irq", 64'(snd_irq_o), modelIrq(1'b1));
            checkOutput("rcv_irq", 64'(rcv_irq_o), modelIrq(1'b0));
            checkOutput("req_ready", 64'(req_ready_o), 64'(!rsp_valid_o || rsp_ready_i));
            if (prevValid && !prevConsumed) begin
                checkOutput("hold_valid", 64'(rsp_valid_o), 64'd1);
                checkOutput("hold_rdata", 64'(rsp_rdata_o), 64'(prevRdata));
                checkOutput("hold_error", 64'(rsp_error_o), 64'(prevErr));
            end
            if (rsp_valid_o && rsp_ready_i) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
                    checkOutput("rsp_error", 64'(rsp_error_o), 64'(e.err));
                end
            end
            prevValid    = rsp_valid_o;
            prevConsumed = rsp_valid_o && rsp_ready_i;
            prevRdata    = rsp_rdata_o;
            prevErr      = rsp_error_o;
            if (req_valid_i && req_ready_o) begin
                modelAccess(req_addr_i, req_write_i, req_wdata_i, req_wstrb_i, rd, er);
                e.rdata = rd;
                e.err   = er;
                sbQ.push_back(e);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic write,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        bit accepted = 1'b0;
        int tries    = 0;
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_write_i = write;
        req_wdata_i = wdata;
        req_wstrb_i = wstrb;
        while (!accepted && tries < 100) begin
            @(negedge clk);
            accepted = req_ready_o;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        req_valid_i = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (sbQ.size() != 0 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (sbQ.size() != 0) checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        write;

        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        checkOutput("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        checkOutput("reset_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
        checkOutput("reset_rsp_error", 64'(rsp_error_o), 64'd0);
        checkOutput("reset_req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #1;

        applyStimulus(Base + 32'h20, 1'b0, '0, 4'h0);

        applyStimulus(Base + 3*64 + 32'h1C, 1'b1, 32'h1, 4'hF);
        applyStimulus(Base + 32'hD4, 1'b1, 32'h1, 4'hF);
        idleCycles(2);
        checkOutput("rcv_irq3_set", 64'(rcv_irq_o[3]), 64'd1);
        applyStimulus(Base + 32'hD8, 1'b1, 32'h1, 4'hF);
        idleCycles(2);
        checkOutput("rcv_irq3_clr", 64'(rcv_irq_o[3]), 64'd0);

        applyStimulus(Base + 24*64 + 32'h24, 1'b1, 32'h0, 4'hF);
        applyStimulus(Base + 24*64 + 32'h24, 1'b1, 32'hDEAD_BEEF, 4'b0101);
        applyStimulus(Base + 24*64 + 32'h24, 1'b0, '0, 4'h0);
        applyStimulus(Base + 24*64 + 32'h24, 1'b1, 32'hFFFF_FFFF, 4'h0);
        applyStimulus(Base + 24*64 + 32'h24, 1'b0, '0, 4'h0);

        applyStimulus(Base + 32'h640, 1'b0, '0, 4'h0);
        applyStimulus(Base + 32'h2, 1'b0, '0, 4'h0);
        applyStimulus(Base + 32'h0, 1'b1, 32'h1, 4'hF);
        applyStimulus(Base + 32'h30, 1'b0, '0, 4'h0);
        applyStimulus(Base - 32'h4, 1'b0, '0, 4'h0);
        applyStimulus(Base + 32'h0, 1'b0, '0, 4'h0);
        applyStimulus(Base + 32'h8C, 1'b1, 32'h1, 4'hF);
        applyStimulus(Base + 32'h84, 1'b1, 32'h1, 4'hF);
        applyStimulus(Base + 32'h94, 1'b1, 32'h1, 4'hF);
        applyStimulus(Base + 32'h80, 1'b0, '0, 4'h0);
        applyStimulus(Base + 32'h84, 1'b0, '0, 4'h0);
        applyStimulus(Base + 32'h88, 1'b1, 32'h1, 4'h0);
        applyStimulus(Base + 32'h80, 1'b0, '0, 4'h0);
        applyStimulus(Base + 3*64 + 32'h20, 1'b1, 32'h1234_5678, 4'hF);
        drain();

        // Stall the response path for three cycles behind back-to-back reads.
        rsp_ready_i = 1'b0;
        fork
            begin
                applyStimulus(Base + 24*64 + 32'h24, 1'b0, '0, 4'h0);
                applyStimulus(Base + 3*64 + 32'h20, 1'b0, '0, 4'h0);
                applyStimulus(Base + 3*64 + 32'h1C, 1'b0, '0, 4'h0);
                applyStimulus(Base + 32'h80, 1'b0, '0, 4'h0);
            end
            begin
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall_req_ready", 64'(req_ready_o), 64'd0);
                    checkOutput("stall_rsp_valid", 64'(rsp_valid_o), 64'd1);
                    @(posedge clk);
                end
                #1 rsp_ready_i = 1'b1;
            end
        join
        drain();

        applyStimulus(Base + 5*64 + 32'h20, 1'b1, 32'hCAFE_F00D, 4'hF);
        applyStimulus(Base + 5*64 + 32'h0C, 1'b1, 32'h1, 4'hF);
        applyStimulus(Base + 5*64 + 32'h04, 1'b1, 32'h1, 4'hF);
        drain();
        rsp_ready_i = 1'b0;
        applyStimulus(Base + 5*64 + 32'h20, 1'b0, '0, 4'h0);
        @(negedge clk);
        checkOutput("pre_reset_valid", 64'(rsp_valid_o), 64'd1);
        checkOutput("pre_reset_irq5", 64'(snd_irq_o[5]), 64'd1);
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_valid", 64'(rsp_valid_o), 64'd0);
        checkOutput("post_reset_snd_irq", 64'(snd_irq_o), 64'd0);
        checkOutput("post_reset_rcv_irq", 64'(rcv_irq_o), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(Base + 5*64 + 32'h20, 1'b0, '0, 4'h0);
        applyStimulus(Base + 24*64 + 32'h24, 1'b0, '0, 4'h0);
        drain();

        randReady = 1'b1;
        for (int n = 0; n < 400; n++) begin
            addr = Base + 32'($urandom_range(0, 26)) * 64 + 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 15) == 0) addr = addr + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) addr = Base - 32'($urandom_range(4, 64));
            write = 1'($urandom_range(0, 1));
            wdata = $urandom;
            if ($urandom_range(0, 1) == 1) wdata[0] = 1'b1;
            wstrb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            applyStimulus(addr, write, wdata, wstrb);
            if ($urandom_range(0, 7) == 0) idleCycles(1);
        end
        randReady = 1'b0;
        @(posedge clk);
        #2 rsp_ready_i = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
